// File: rtl/change_logger_defs.sv
// Shared definitions for the change logger: FSM state encodings and
// drop-counter sizing.
package change_logger_defs;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int                DROP_W   = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/change_logger_sync_fifo.sv
// Synchronous FIFO holding timestamped events. Pointers carry an extra MSB
// so full and empty are distinguished without a separate counter. A push
// into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int width = 18,
   parameter int depth = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [width-1:0]           din,
   input  logic                       pop,
   output logic [width-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(depth):0]     level
);

   localparam int             aw       = $clog2(depth);
   localparam logic [aw:0]    FULL_LVL = (aw + 1)'(depth);
   localparam logic [aw:0]    PTR_ONE  = {{aw{1'b0}}, 1'b1};

   logic [width-1:0] mem [depth];
   logic [aw:0]      wptr;
   logic [aw:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign level   = wptr - rptr;
   assign full    = (level == FULL_LVL);
   assign empty   = (wptr == rptr);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rptr[aw-1:0]];

   // Advance read/write pointers on accepted pushes and pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Write event payload into storage; storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[aw-1:0]] <= din;
   end

endmodule

// File: rtl/change_logger.sv
// Change logger: samples a bus every clock, turns value changes into
// {value, timestamp} events and queues them for a valid/ready consumer.
// Events arriving at a full FIFO with no simultaneous pop are dropped and
// accounted in a sticky overflow flag and a saturating drop counter.
module change_logger
   import change_logger_defs::*;
#(
   parameter int bsize = 1,
   parameter int depth = 4,
   parameter int tsize = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [bsize-1:0]          b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [bsize-1:0]          out_value,
   output logic [tsize-1:0]          out_time,
   output logic [$clog2(depth):0]    level,
   output logic                      overflow,
   output logic [DROP_W-1:0]         drop_cnt
);

   localparam int               fw     = bsize + tsize;
   localparam logic [tsize-1:0] TS_ONE = {{(tsize-1){1'b0}}, 1'b1};

   state_t           state;
   logic [bsize-1:0] prev;
   logic [tsize-1:0] ts;
   logic             event_vld;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [fw-1:0]    fifo_dout;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == DROP_MAX) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
   endfunction

   // The INIT cycle logs the bus unconditionally; afterwards only changes.
   assign event_vld = (state == INIT) || (b != prev);
   assign pop       = out_valid && out_ready;
   assign drop      = event_vld && fifo_full && !pop;

   assign out_valid = !fifo_empty;
   assign out_value = fifo_dout[fw-1:tsize];
   assign out_time  = fifo_dout[tsize-1:0];

   sync_fifo #(
      .width (fw),
      .depth (depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (event_vld),
      .din   ({b, ts}),
      .pop   (out_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // State machine, free-running timestamp and drop accounting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= INIT;
         ts       <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         ts <= ts + TS_ONE;
         case (state)
            INIT:    state <= RUN;
            default: state <= RUN;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
         end
      end
   end

   // Track the last logged value, even when its event was dropped.
   always_ff @(posedge clk) begin
      if (event_vld) prev <= b;
   end

endmodule

// File: tb/tb_change_logger.sv
// Directed bench for change_logger (bsize=2, depth=4, tsize=4).
module tb_change_logger;

   logic       clk;
   logic       rst;
   logic [1:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_value;
   logic [3:0] out_time;
   logic [2:0] level;
   logic       overflow;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] b;
      logic       rdy;
      logic       valid;
      logic [1:0] value;
      logic [3:0] tm;
      logic [2:0] lvl;
   } vec_t;

   vec_t tbl [12];

   change_logger #(
      .bsize (2),
      .depth (4),
      .tsize (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_time  (out_time),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", nm, act, exp);
      end
   endtask

   // one active edge, return at the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic head(input string nm, input logic [1:0] v, input logic [3:0] t);
      chk({nm, "_valid"}, 32'(out_valid), 32'd1);
      if (out_valid) begin
         chk({nm, "_value"}, 32'(out_value), 32'(v));
         chk({nm, "_time"}, 32'(out_time), 32'(t));
      end
   endtask

   // assert reset across one edge, release at a falling edge
   task automatic do_reset(input logic [1:0] bv, input logic rdy);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      b = bv;
      out_ready = rdy;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b = 2'd0;
      out_ready = 1'b0;

      tbl[0]  = '{b: 2'd0, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[1]  = '{b: 2'd0, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[2]  = '{b: 2'd0, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[3]  = '{b: 2'd0, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[4]  = '{b: 2'd1, rdy: 1'b1, valid: 1'b1, value: 2'd1, tm: 4'd5,  lvl: 3'd1};
      tbl[5]  = '{b: 2'd1, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[6]  = '{b: 2'd1, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[7]  = '{b: 2'd1, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[8]  = '{b: 2'd1, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};
      tbl[9]  = '{b: 2'd2, rdy: 1'b1, valid: 1'b1, value: 2'd2, tm: 4'd10, lvl: 3'd1};
      tbl[10] = '{b: 2'd2, rdy: 1'b0, valid: 1'b1, value: 2'd2, tm: 4'd10, lvl: 3'd1};
      tbl[11] = '{b: 2'd2, rdy: 1'b1, valid: 1'b0, value: 2'd0, tm: 4'd0,  lvl: 3'd0};

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_value", 32'(out_value), 32'd0);
      chk("rst_time", 32'(out_time), 32'd0);

      // INIT edge logs {00, 0}
      rst = 1'b0;
      tick();
      chk("init_level", 32'(level), 32'd1);
      head("init", 2'd0, 4'd0);

      // change sequence, edges 1..12
      for (int i = 0; i < 12; i++) begin
         b = tbl[i].b;
         out_ready = tbl[i].rdy;
         tick();
         chk($sformatf("seq%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
         chk($sformatf("seq%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         if (tbl[i].valid) begin
            chk($sformatf("seq%0d_value", i), 32'(out_value), 32'(tbl[i].value));
            chk($sformatf("seq%0d_time", i), 32'(out_time), 32'(tbl[i].tm));
         end
         chk($sformatf("seq%0d_drop", i), 32'(drop_cnt), 32'd0);
      end

      // overflow: INIT plus 7 toggles with no consumer
      do_reset(2'd0, 1'b0);
      tick();
      for (int i = 1; i <= 7; i++) begin
         b = 2'(i % 2);
         tick();
         chk($sformatf("ovf%0d_level", i), 32'(level), 32'((i + 1 > 4) ? 4 : i + 1));
         chk($sformatf("ovf%0d_drop", i), 32'(drop_cnt), 32'((i > 3) ? i - 3 : 0));
         chk($sformatf("ovf%0d_flag", i), 32'(overflow), 32'(i > 3));
      end
      head("ovf_head", 2'd0, 4'd0);

      // full FIFO, change and pop on the same edge (edge 8)
      b = 2'd0;
      out_ready = 1'b1;
      tick();
      chk("fp_level", 32'(level), 32'd4);
      chk("fp_drop", 32'(drop_cnt), 32'd4);
      head("fp_h1", 2'd1, 4'd1);
      tick();
      chk("fp_level2", 32'(level), 32'd3);
      head("fp_h2", 2'd0, 4'd2);
      tick();
      head("fp_h3", 2'd1, 4'd3);
      tick();
      chk("fp_level4", 32'(level), 32'd1);
      head("fp_h4", 2'd0, 4'd8);
      tick();
      chk("fp_empty", 32'(out_valid), 32'd0);

      // timestamp wrap: changes at edges 15 and 17
      do_reset(2'd0, 1'b0);
      tick();
      for (int e = 1; e <= 17; e++) begin
         b = (e >= 17) ? 2'd2 : ((e >= 15) ? 2'd1 : 2'd0);
         tick();
      end
      chk("wrap_level", 32'(level), 32'd3);
      head("wrap_h0", 2'd0, 4'd0);
      out_ready = 1'b1;
      tick();
      head("wrap_h1", 2'd1, 4'd15);
      tick();
      head("wrap_h2", 2'd2, 4'd1);
      tick();
      chk("wrap_empty", 32'(level), 32'd0);

      // drop counter saturation
      do_reset(2'd0, 1'b0);
      tick();
      for (int i = 1; i <= 300; i++) begin
         b = 2'(i % 2);
         tick();
         if (i == 257) chk("sat_254", 32'(drop_cnt), 32'd254);
      end
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      chk("sat_flag", 32'(overflow), 32'd1);
      chk("sat_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      tick();
      chk("sat_level3", 32'(level), 32'd3);

      // asynchronous reset between edges with 3 events queued
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_drop", 32'(drop_cnt), 32'd0);
      chk("arst_flag", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      b = 2'd3;
      tick();
      chk("arst_level1", 32'(level), 32'd1);
      head("arst_h", 2'd3, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
